key_search_coordinator: RTL and testbench
=========================================

Name: key_search_coordinator

Overview:
- Supervises NUM_CORES parallel RC4 key-search cores, each a KSA, permutation and decrypt-check pipeline that sweeps its own slice of the key space.
- Partitions the key space and launches all cores together. Collects their solution and exhaustion flags, broadcasts stop, and latches the winning key and core index.
- Sits between the board-level top (switches, LEDs, HEX decoders) and the core array. It is the receiving end of each core's solution/stop handshake.

Parameters:
- NUM_CORES, 4: number of search cores; power of two, 1..16.
- KEY_W, 24: secret key width in bits.
- KEY_LIMIT, 24'h400000: exclusive upper bound of the searched key space; the top two key bits are always zero.
- TIMEOUT_CYCLES, 0: search abandoned after this many SEARCH cycles; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- go  in  1  one-cycle pulse that starts or restarts a search
- core_start  out  NUM_CORES  one-cycle start pulse per core
- core_base_key  out  NUM_CORES*KEY_W  first key for core i, in slice i
- core_range_len  out  KEY_W  number of keys per core
- core_solution  in  NUM_CORES  level; core i has decrypted valid text
- core_key  in  NUM_CORES*KEY_W  key currently held by core i
- core_exhausted  in  NUM_CORES  level; core i finished its range with no solution
- stop  out  1  broadcast halt to all cores
- busy  out  1  high in LAUNCH and SEARCH
- found  out  1  solution latched
- found_key  out  KEY_W  winning key
- found_core  out  4  index of the winning core
- fail  out  1  all cores exhausted, or timeout
- elapsed  out  32  SEARCH cycle count, saturating

Behaviour:
- Reset values: all outputs 0, state IDLE, exhausted mask 0.
- Constants:
  - RANGE = KEY_LIMIT / NUM_CORES.
  - core_base_key slice i = i*RANGE, truncated to KEY_W.
  - core_range_len = RANGE.
  - These are constant and registered; they are valid whenever core_start is pulsed.
- FSM states: IDLE, LAUNCH, SEARCH, FOUND, FAIL.
- IDLE: on go, go to LAUNCH.
- LAUNCH, one cycle:
  - core_start = all ones.
  - Clear found, fail, found_key, found_core, elapsed, the exhausted mask and stop.
  - Go to SEARCH.
- SEARCH:
  - elapsed increments every cycle and saturates at 32'hFFFFFFFF.
  - The exhausted mask ORs in core_exhausted each cycle.
  - Priority 1: if any core_solution bit is high, the lowest index i wins. On the next edge set found_key = core_key[i], found_core = i, found = 1, stop = 1, and go to FOUND.
  - Priority 2: if (mask | core_exhausted) is all ones, set fail = 1, stop = 1, and go to FAIL.
  - Priority 3: if TIMEOUT_CYCLES != 0 and elapsed == TIMEOUT_CYCLES-1, set fail = 1, stop = 1, and go to FAIL.
- FOUND and FAIL:
  - Terminal and holding; stop stays high.
  - Later changes on core_solution or core_key are ignored; latched values never change.
- go in FOUND or FAIL: go to LAUNCH; stop drops in the LAUNCH cycle.
- go in LAUNCH or SEARCH: ignored.
- Latency:
  - go to core_start: 1 cycle.
  - core_solution high to found/stop high: 1 cycle.
- Simultaneous events:
  - Solution and last exhaustion in the same cycle: FOUND.
  - Solution and timeout in the same cycle: FOUND.
  - Multiple solutions in the same cycle: lowest index wins.
- reset asserted mid-search: returns to IDLE with reset values next edge; stop drops. Cores are reset by the same signal.
- busy = (state == LAUNCH || state == SEARCH).

Decomposition:
- Package key_search_pkg holds:
  - enum coord_state_t {IDLE, LAUNCH, SEARCH, FOUND, FAIL};
  - KEY_W_DEFAULT and KEY_LIMIT_DEFAULT;
  - function first_set_idx(vector) returning a 4-bit index.
- One sub-module, lowest_index_arbiter: a fixed-priority encoder giving a valid bit and an index. It is instantiated once, for core_solution.

Test Plan:
1. NUM_CORES=4, reset, go:
   - core_start = 4'b1111 for exactly 1 cycle, 1 cycle after go.
   - Base keys are 0, 0x100000, 0x200000, 0x300000.
   - core_range_len = 0x100000.
2. Core 2 raises core_solution with core_key = 0x2A1B3C at SEARCH cycle 50:
   - Next edge gives found = 1, found_key = 0x2A1B3C, found_core = 2, stop = 1, elapsed = 51.
   - elapsed then holds.
3. Cores 1 and 3 solve in the same cycle with keys 0x1000FF and 0x3000AA:
   - found_core = 1, found_key = 0x1000FF.
4. Cores raise core_exhausted one at a time in cycles 10, 20, 30 and 40:
   - fail = 1 and stop = 1 after the cycle-40 edge; found = 0.
   - Repeat with a solution on core 0 in cycle 40: found wins.
5. TIMEOUT_CYCLES=100 with no core activity:
   - fail = 1 after 100 SEARCH cycles.
   - A following go relaunches, clearing fail, stop and elapsed.
6. reset pulsed at SEARCH cycle 20:
   - All outputs 0 and state IDLE next cycle.
   - go pulses during SEARCH produce no extra core_start.

Source files
------------

// File: rtl/key_search_pkg.sv
// Shared types and helpers for the RC4 key-search coordinator and its arbiter.
package key_search_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    SEARCH,
    FOUND,
    FAIL
  } coord_state_t;

  localparam int          KEY_W_DEFAULT     = 24;
  localparam int unsigned KEY_LIMIT_DEFAULT = 32'h0040_0000;

  // Lowest set bit wins; an all-zero vector yields index 0.
  function automatic logic [3:0] first_set_idx(input logic [15:0] vec);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_search_coordinator_if.sv
// Coordinator <-> core-array bundle: launch parameters out, solution/exhaustion flags back.
interface key_search_coordinator_if #(
  parameter int NUM_CORES = 4,
  parameter int KEY_W     = 24
);
  logic [NUM_CORES-1:0]       core_start;
  logic [NUM_CORES*KEY_W-1:0] core_base_key;
  logic [KEY_W-1:0]           core_range_len;
  logic [NUM_CORES-1:0]       core_solution;
  logic [NUM_CORES*KEY_W-1:0] core_key;
  logic [NUM_CORES-1:0]       core_exhausted;
  logic                       stop;

  modport master (
    output core_start, core_base_key, core_range_len, stop,
    input  core_solution, core_key, core_exhausted
  );

  modport slave (
    input  core_start, core_base_key, core_range_len, stop,
    output core_solution, core_key, core_exhausted
  );
endinterface

// File: rtl/key_search_coordinator_arbiter.sv
// Fixed-priority encoder: the lowest requesting index wins.
module lowest_index_arbiter
  import key_search_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [3:0]   idx
);

  logic [15:0] padded;

  always_comb begin
    padded        = '0;
    padded[N-1:0] = req;
  end

  assign valid = |req;
  assign idx   = first_set_idx(padded);

endmodule

// File: rtl/key_search_coordinator.sv
// Launches NUM_CORES key-search cores over equal key-space slices, then latches
// the first solution (lowest core index on ties), total exhaustion, or a timeout.
module key_search_coordinator
  import key_search_pkg::*;
#(
  parameter int          NUM_CORES      = 4,
  parameter int          KEY_W          = KEY_W_DEFAULT,
  parameter int unsigned KEY_LIMIT      = KEY_LIMIT_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      go,
  key_search_coordinator_if.master  cores,
  output logic                      busy,
  output logic                      found,
  output logic [KEY_W-1:0]          found_key,
  output logic [3:0]                found_core,
  output logic                      fail,
  output logic [31:0]               elapsed
);

  localparam int unsigned RANGE = KEY_LIMIT / NUM_CORES;

  coord_state_t               state;
  logic [NUM_CORES-1:0]       exhausted_mask;
  logic [NUM_CORES-1:0]       start_q;
  logic                       stop_q;
  logic [NUM_CORES*KEY_W-1:0] base_q;
  logic [KEY_W-1:0]           range_q;

  logic                 sol_valid;
  logic [3:0]           sol_idx;
  logic [KEY_W-1:0]     sol_key;
  logic [NUM_CORES-1:0] exhausted_now;
  logic                 timeout_hit;

  lowest_index_arbiter #(.N(NUM_CORES)) u_arb (
    .req   (cores.core_solution),
    .valid (sol_valid),
    .idx   (sol_idx)
  );

  assign sol_key       = cores.core_key[int'(sol_idx)*KEY_W +: KEY_W];
  assign exhausted_now = exhausted_mask | cores.core_exhausted;
  assign timeout_hit   = (TIMEOUT_CYCLES != 0) && (elapsed == 32'(TIMEOUT_CYCLES - 1));

  assign busy                 = (state == LAUNCH) || (state == SEARCH);
  assign cores.core_start     = start_q;
  assign cores.core_base_key  = base_q;
  assign cores.core_range_len = range_q;
  assign cores.stop           = stop_q;

  // Slice layout never changes; registered so the cores see clean flop outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q  <= '0;
      range_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        base_q[i*KEY_W +: KEY_W] <= KEY_W'(32'(i) * RANGE);
      end
      range_q <= KEY_W'(RANGE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      start_q        <= '0;
      stop_q         <= 1'b0;
      found          <= 1'b0;
      fail           <= 1'b0;
      found_key      <= '0;
      found_core     <= '0;
      elapsed        <= '0;
      exhausted_mask <= '0;
    end else begin
      start_q <= '0;
      case (state)
        IDLE, FOUND, FAIL: begin
          // Results are cleared on entry so they already read zero during LAUNCH.
          if (go) begin
            state          <= LAUNCH;
            start_q        <= '1;
            stop_q         <= 1'b0;
            found          <= 1'b0;
            fail           <= 1'b0;
            found_key      <= '0;
            found_core     <= '0;
            elapsed        <= '0;
            exhausted_mask <= '0;
          end
        end
        LAUNCH: state <= SEARCH;
        SEARCH: begin
          if (elapsed != 32'hFFFF_FFFF) elapsed <= elapsed + 32'd1;
          exhausted_mask <= exhausted_now;
          if (sol_valid) begin
            found      <= 1'b1;
            found_key  <= sol_key;
            found_core <= sol_idx;
            stop_q     <= 1'b1;
            state      <= FOUND;
          end else if ((&exhausted_now) || timeout_hit) begin
            fail   <= 1'b1;
            stop_q <= 1'b1;
            state  <= FAIL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_search_coordinator.sv
// Scoreboard bench: stimulus pushes launch/result expectations from a timeline model,
// a negedge monitor pops them whenever the DUT pulses core_start or latches a result.
module tb_key_search_coordinator;
  import key_search_pkg::*;

  localparam int NC    = 4;
  localparam int KW    = 24;
  localparam int TO    = 100;
  localparam int LIMIT = 32'h0040_0000;
  localparam int RANGE = LIMIT / NC;
  localparam int NEVER = 1_000_000;

  typedef struct {
    bit            found;
    bit            fail;
    logic [KW-1:0] key;
    logic [3:0]    core;
    logic [31:0]   elapsed;
    int            end_cycle;
  } res_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic          busy, found, fail;
  logic [KW-1:0] found_key;
  logic [3:0]    found_core;
  logic [31:0]   elapsed;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  res_t res_q[$];
  int   launch_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_search_coordinator_if #(.NUM_CORES(NC), .KEY_W(KW)) cif ();

  key_search_coordinator #(
    .NUM_CORES(NC), .KEY_W(KW), .KEY_LIMIT(LIMIT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .cores(cif.master), .busy(busy),
    .found(found), .found_key(found_key), .found_core(found_core),
    .fail(fail), .elapsed(elapsed)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cores(input logic [NC-1:0] sol, input logic [NC-1:0] exh, input logic [KW-1:0] k[NC]);
    cif.core_solution  = sol;
    cif.core_exhausted = exh;
    for (int i = 0; i < NC; i++) cif.core_key[i*KW +: KW] = k[i];
  endtask

  // Outcome from the event timeline: earliest solution, last exhaustion, or timeout.
  function automatic res_t model(input int s[NC], input int x[NC], input logic [KW-1:0] k[NC]);
    res_t r;
    int ts = NEVER, te = 0;
    for (int i = 0; i < NC; i++) begin
      if (s[i] < ts) ts = s[i];
      if (x[i] > te) te = x[i];
    end
    r.key = '0; r.core = '0; r.found = 1'b0; r.fail = 1'b0;
    if (ts <= te && ts <= TO - 1) begin
      r.found = 1'b1;
      r.end_cycle = ts;
      for (int i = NC - 1; i >= 0; i--) begin
        if (s[i] == ts) begin r.core = 4'(i); r.key = k[i]; end
      end
    end else begin
      r.fail = 1'b1;
      r.end_cycle = (te <= TO - 1) ? te : TO - 1;
    end
    r.elapsed = 32'(r.end_cycle + 1);
    return r;
  endfunction

  task automatic applyStimulus(input int s[NC], input int x[NC], input logic [KW-1:0] k[NC]);
    res_t r;
    logic [KW-1:0] junk[NC];
    logic [NC-1:0] sol, exh;
    drive_cores('0, '0, k);
    go = 1'b1;
    launch_q.push_back(cyc + 1);
    tick();
    go = 1'b0;
    tick();
    r = model(s, x, k);
    res_q.push_back(r);
    for (int c = 0; c <= r.end_cycle; c++) begin
      for (int i = 0; i < NC; i++) begin
        sol[i] = (c >= s[i]);
        exh[i] = (c >= x[i]);
      end
      drive_cores(sol, exh, k);
      tick();
    end
    for (int h = 0; h < 3; h++) begin
      for (int i = 0; i < NC; i++) junk[i] = KW'($urandom);
      drive_cores(NC'($urandom), NC'($urandom), junk);
      tick();
    end
    checkOutput("hold_found", 32'(found), 32'(r.found));
    checkOutput("hold_fail", 32'(fail), 32'(r.fail));
    checkOutput("hold_key", 32'(found_key), 32'(r.key));
    checkOutput("hold_core", 32'(found_core), 32'(r.core));
    checkOutput("hold_elapsed", elapsed, r.elapsed);
    checkOutput("hold_stop", 32'(cif.stop), 32'd1);
    drive_cores('0, '0, k);
  endtask

  // Monitor: every core_start pulse and every newly latched result must match a queued expectation.
  initial begin
    bit   prev = 1'b0;
    int   ec;
    res_t r;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
      end else begin
        if (cif.core_start != '0) begin
          if (launch_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected_core_start: got 0x%0h, expected 0x0", cif.core_start);
          end else begin
            ec = launch_q.pop_front();
            checkOutput("start_cycle", 32'(cyc), 32'(ec));
            checkOutput("core_start", 32'(cif.core_start), 32'({NC{1'b1}}));
            for (int i = 0; i < NC; i++)
              checkOutput($sformatf("base_key%0d", i), 32'(cif.core_base_key[i*KW +: KW]), 32'(i * RANGE));
            checkOutput("range_len", 32'(cif.core_range_len), 32'(RANGE));
            checkOutput("launch_cleared", {29'd0, found, fail, cif.stop}, 32'd0);
            checkOutput("launch_elapsed", elapsed, 32'd0);
            checkOutput("launch_busy", 32'(busy), 32'd1);
          end
        end
        if ((found | fail) && !prev) begin
          if (res_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected_result: got found=%0b fail=%0b, expected none", found, fail);
          end else begin
            r = res_q.pop_front();
            checkOutput("res_found", 32'(found), 32'(r.found));
            checkOutput("res_fail", 32'(fail), 32'(r.fail));
            checkOutput("res_key", 32'(found_key), 32'(r.key));
            checkOutput("res_core", 32'(found_core), 32'(r.core));
            checkOutput("res_elapsed", elapsed, r.elapsed);
            checkOutput("res_stop", 32'(cif.stop), 32'd1);
            checkOutput("res_busy", 32'(busy), 32'd0);
          end
        end
        prev = found | fail;
      end
    end
  end

  initial begin
    int            s[NC];
    int            x[NC];
    logic [KW-1:0] k[NC];
    logic [NC-1:0] none;
    none = '0;
    reset = 1'b1;
    go    = 1'b0;
    for (int i = 0; i < NC; i++) k[i] = KW'(i * RANGE + $urandom_range(0, RANGE - 1));
    drive_cores(none, none, k);
    repeat (3) tick();
    checkOutput("reset_outputs", {27'd0, busy, found, fail, cif.stop, |cif.core_start}, 32'd0);
    checkOutput("reset_key_core", {4'd0, found_key, found_core}, 32'd0);
    checkOutput("reset_elapsed", elapsed, 32'd0);
    reset = 1'b0;
    tick();

    // Single solution on core 2 at SEARCH cycle 50.
    s = '{NEVER, NEVER, 50, NEVER}; x = '{NEVER, NEVER, NEVER, NEVER};
    k[2] = 24'h2A1B3C;
    applyStimulus(s, x, k);

    // Simultaneous solutions on cores 1 and 3.
    s = '{NEVER, 12, NEVER, 12};
    k[1] = 24'h1000FF; k[3] = 24'h3000AA;
    applyStimulus(s, x, k);

    // Staggered exhaustion, then the same with a solution on the last exhaustion cycle.
    s = '{NEVER, NEVER, NEVER, NEVER}; x = '{10, 20, 30, 40};
    applyStimulus(s, x, k);
    s = '{40, NEVER, NEVER, NEVER};
    applyStimulus(s, x, k);

    // No activity: timeout, then a relaunch that must clear everything.
    s = '{NEVER, NEVER, NEVER, NEVER}; x = '{NEVER, NEVER, NEVER, NEVER};
    applyStimulus(s, x, k);

    // Reset mid-search, with go pulses in LAUNCH and SEARCH that must be ignored.
    go = 1'b1;
    launch_q.push_back(cyc + 1);
    tick();
    tick();
    for (int c = 0; c < 20; c++) begin
      go = (c == 5 || c == 6);
      tick();
    end
    go    = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midreset_flags", {27'd0, busy, found, fail, cif.stop, |cif.core_start}, 32'd0);
    checkOutput("midreset_elapsed", elapsed, 32'd0);
    checkOutput("midreset_key_core", {4'd0, found_key, found_core}, 32'd0);
    tick();

    // Randomized timelines.
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < NC; i++) begin
        s[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 120)) : NEVER;
        x[i] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 120)) : NEVER;
        k[i] = KW'(i * RANGE + $urandom_range(0, RANGE - 1));
      end
      applyStimulus(s, x, k);
    end

    repeat (5) tick();
    checkOutput("pending_results", 32'(res_q.size()), 32'd0);
    checkOutput("pending_launches", 32'(launch_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
